spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
- Synthesizable, parametrised SPI register-file slave. Mode 0, MSB first, command/address/data framing: 0x0B = read, 0x0A = write.
- Generalises the bench's accelerometer emulation:
  - configurable register count and width;
  - real writes, read-only region and auto-increment with wrap;
  - write-side strobes toward the rest of the system.
- Sits on the CS/SCLK/MOSI/MISO pins in place of the external sensor. It is used both as a bench device model and as an on-chip test target.

Parameters:
- NUM_REGS, 20, number of data registers (2..256).
- DATA_W, 8, register and SPI byte width in bits (8 or 16).
- ADDR_W, 8, width of the address phase in bits; must satisfy 2**ADDR_W >= NUM_REGS.
- RO_REGS, 0, registers 0..RO_REGS-1 are read-only.
- RESET_IDX, 1, if 1 then reg[i] resets to i[DATA_W-1:0]; if 0 then all registers reset to 0.
- CMD_READ, 8'h0B, read opcode.
- CMD_WRITE, 8'h0A, write opcode.

Ports:
- SCLK  in  1  serial clock; the only clock in the block.
- resetn  in  1  reset; synchronous to SCLK, active-low.
- CS  in  1  chip select, active-low; sampled on SCLK rise.
- MOSI  in  1  serial data in; sampled on SCLK rise.
- MISO  out  1  serial data out; registered, updated on SCLK rise.
- regs_o  out  NUM_REGS*DATA_W  flat register image; reg[i] at bits [i*DATA_W +: DATA_W].
- wr_pulse  out  1  one-SCLK-cycle pulse on each committed write.
- wr_addr  out  ADDR_W  address of the committed write.
- wr_data  out  DATA_W  data of the committed write.
- busy  out  1  high while a frame is in progress (state != CMD or bit count != 0).

Behaviour:
- All logic is clocked on SCLK rising edge. Reset is synchronous to SCLK, active-low, and takes effect on the next SCLK rise.
- Reset values:
  - MISO = 0, wr_pulse = 0, wr_addr = 0, wr_data = 0, busy = 0.
  - state = CMD, bit count = 0.
  - registers per RESET_IDX.
- Frame abort:
  - CS = 1 at a rise forces state = CMD, bit count = 0, MISO = 0, wr_pulse = 0.
  - A partial data byte is discarded; no write occurs.
  - Register contents are kept.
- States:
  - CMD: shift 8 MOSI bits into the command register, then go to ADDR.
  - ADDR: shift ADDR_W bits into the pointer. On the last bit:
    - command == CMD_READ: go to RD, load the shifter with reg[ptr], and drive MISO with its MSB on that same edge.
    - command == CMD_WRITE: go to WR.
    - any other command: go to IGN.
  - RD:
    - shift the shifter left each rise; MISO = next bit.
    - After DATA_W bits: ptr = ptr+1 (wrap to 0 after NUM_REGS-1) and reload from the new ptr; the new MSB appears on the same edge.
    - Bursts are unbounded.
  - WR:
    - shift MOSI in.
    - On bit DATA_W, commit: if ptr >= RO_REGS and ptr < NUM_REGS, write reg[ptr] and pulse wr_pulse with wr_addr/wr_data for one SCLK cycle.
    - Then increment ptr with the same wrap and continue.
  - IGN: MISO = 0 until CS rises.
- Timing: master samples MISO on rise k+1 for a bit driven on rise k. The first read bit is driven on edge 8+ADDR_W.
- Out-of-range and read-only handling:
  - ptr >= NUM_REGS: reads return 0, writes are dropped (no wr_pulse), increment continues and wraps at NUM_REGS-1 only when in range.
  - Writes to read-only registers are dropped silently; no wr_pulse.
- Reset during a frame takes priority over all else; next frame starts in CMD.

Optional Feature:
- Macro SPI_REG_SLAVE_CMD_ERR_EN.
- With it defined:
  - adds output cmd_err (1 bit, sticky; cleared by reset or by a committed write of any value to address NUM_REGS-1).
  - adds output err_cnt (8 bits, saturating at 255).
  - An unknown opcode sets cmd_err and increments err_cnt; in IGN, MISO = 1.
- Without it: ports absent; IGN drives MISO = 0.

Decomposition:
- Shared package/header spi_slave_defs: opcode constants READ 8'h0B, WRITE 8'h0A; state encodings CMD/ADDR/RD/WR/IGN; the pointer-wrap function.
- One sub-module is natural: spi_shift_unit, holding the bit counter, MOSI shift-in and MISO shift-out/load. The FSM and register file stay in the top level.

Test Plan:
- Reset state: hold resetn = 0 for 2 SCLK -> all outputs 0; regs_o reg[5] = 8'h05.
- Burst read with wrap: frame 0x0B, addr 0x12, read 4 bytes -> MISO bytes 0x12, 0x13, 0x00, 0x01 (NUM_REGS = 20).
- Write then read back: write frame 0x0A, 0x03, 0xA5, 0x5A -> wr_pulse twice (addr 3 data 0xA5, addr 4 data 0x5A); readback gives 0xA5, 0x5A.
- Abort and read-only: CS high after 4 data bits of a write to addr 7 -> reg[7] stays 0x07, no wr_pulse. With RO_REGS = 2, write 0xFF to addr 1 -> reg[1] stays 0x01, no wr_pulse.
- Unknown opcode: opcode 0x55 -> MISO = 0 for the whole frame, no writes. With SPI_REG_SLAVE_CMD_ERR_EN: cmd_err = 1, err_cnt = 1, MISO = 1.
- Out-of-range address: read addr 0x40 -> 0x00 returned; write addr 0x40 -> no wr_pulse, regs_o unchanged.

Source files
------------

// File: rtl/spi_slave_defs.sv
// Shared definitions for the SPI register slave: opcodes, FSM state encodings, pointer advance.
package spi_slave_defs;
  localparam logic [7:0] OP_READ  = 8'h0B;
  localparam logic [7:0] OP_WRITE = 8'h0A;

  localparam logic [2:0] ST_CMD  = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_IGN  = 3'd4;

  localparam int CNT_W = 5;

  // Wraps to 0 only from the last implemented register; out-of-range pointers roll naturally.
  function automatic logic [15:0] ptr_wrap(input logic [15:0] p, input int num_regs);
    if (32'(p) == num_regs - 1) return 16'd0;
    return p + 16'd1;
  endfunction
endpackage

// File: rtl/spi_shift_unit.sv
// Phase bit counter, MOSI shift-in and registered MISO shift-out/load for spi_reg_slave.
import spi_slave_defs::*;

module spi_shift_unit #(
  parameter int SH_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic              SCLK,
  input  logic              clr_i,
  input  logic              cnt_en_i,
  input  logic [CNT_W-1:0]  last_idx_i,
  output logic              last_o,
  output logic [CNT_W-1:0]  cnt_o,
  input  logic              mosi_i,
  output logic [SH_W-1:0]   sin_d_o,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_dat_i,
  input  logic              shift_i,
  input  logic              miso_idle_i,
  output logic              miso_o
);
  logic [CNT_W-1:0]  cnt_q;
  logic [SH_W-2:0]   sin_q;
  logic [DATA_W-1:0] sout_q;
  logic              miso_q;

  assign last_o  = (cnt_q == last_idx_i);
  assign cnt_o   = cnt_q;
  assign sin_d_o = {sin_q, mosi_i};
  assign miso_o  = miso_q;

  // sout_q holds the bits still to be sent; the bit on the pin lives in miso_q.
  always_ff @(posedge SCLK) begin
    if (clr_i) begin
      cnt_q  <= '0;
      sout_q <= '0;
      miso_q <= 1'b0;
    end else begin
      if (cnt_en_i) cnt_q <= last_o ? '0 : cnt_q + CNT_W'(1);
      if (load_i) begin
        sout_q <= {load_dat_i[DATA_W-2:0], 1'b0};
        miso_q <= load_dat_i[DATA_W-1];
      end else if (shift_i) begin
        sout_q <= {sout_q[DATA_W-2:0], 1'b0};
        miso_q <= sout_q[DATA_W-1];
      end else begin
        miso_q <= miso_idle_i;
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (cnt_en_i) sin_q <= sin_d_o[SH_W-2:0];
  end
endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file slave with cmd/addr/data framing, auto-increment bursts and write strobes.
// Build option SPI_REG_SLAVE_CMD_ERR_EN adds sticky cmd_err and saturating err_cnt for unknown opcodes.
import spi_slave_defs::*;

module spi_reg_slave #(
  parameter int         NUM_REGS  = 20,
  parameter int         DATA_W    = 8,
  parameter int         ADDR_W    = 8,
  parameter int         RO_REGS   = 0,
  parameter int         RESET_IDX = 1,
  parameter logic [7:0] CMD_READ  = OP_READ,
  parameter logic [7:0] CMD_WRITE = OP_WRITE
) (
  input  logic                       SCLK,
  input  logic                       resetn,
  input  logic                       CS,
  input  logic                       MOSI,
  output logic                       MISO,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_pulse,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [DATA_W-1:0]          wr_data,
  output logic                       busy
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
  ,
  output logic                       cmd_err,
  output logic [7:0]                 err_cnt
`endif
);
  localparam int AD_MAX = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SH_W   = (AD_MAX > 8) ? AD_MAX : 8;
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
  localparam logic IGN_MISO = 1'b1;
`else
  localparam logic IGN_MISO = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [7:0]        cmd_q, cmd_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_pulse_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              last, load, shift, commit, miso_idle;
  logic [CNT_W-1:0]  cnt, last_idx;
  logic [SH_W-1:0]   sin_d;
  logic [DATA_W-1:0] rd_val;
  int                ptr_int;

  spi_shift_unit #(.SH_W(SH_W), .DATA_W(DATA_W)) u_shift (
    .SCLK        (SCLK),
    .clr_i       (!resetn || CS),
    .cnt_en_i    (!CS),
    .last_idx_i  (last_idx),
    .last_o      (last),
    .cnt_o       (cnt),
    .mosi_i      (MOSI),
    .sin_d_o     (sin_d),
    .load_i      (load),
    .load_dat_i  (rd_val),
    .shift_i     (shift),
    .miso_idle_i (miso_idle),
    .miso_o      (MISO)
  );

  always_comb begin
    case (state_q)
      ST_CMD:  last_idx = CNT_W'(7);
      ST_ADDR: last_idx = CNT_W'(ADDR_W - 1);
      default: last_idx = CNT_W'(DATA_W - 1);
    endcase
  end

  always_comb begin
    ptr_int = 32'(ptr_q);
    state_d = state_q;
    cmd_d   = cmd_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
    shift   = 1'b0;
    commit  = 1'b0;
    if (CS) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_CMD: if (last) begin
          cmd_d   = sin_d[7:0];
          state_d = ST_ADDR;
        end
        ST_ADDR: if (last) begin
          ptr_d = sin_d[ADDR_W-1:0];
          if (cmd_q == CMD_READ) begin
            state_d = ST_RD;
            load    = 1'b1;
          end else if (cmd_q == CMD_WRITE) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_IGN;
          end
        end
        ST_RD: if (last) begin
          ptr_d = ADDR_W'(ptr_wrap(16'(ptr_q), NUM_REGS));
          load  = 1'b1;
        end else begin
          shift = 1'b1;
        end
        ST_WR: if (last) begin
          commit = (ptr_int >= RO_REGS) && (ptr_int < NUM_REGS);
          ptr_d  = ADDR_W'(ptr_wrap(16'(ptr_q), NUM_REGS));
        end
        default: ;
      endcase
    end
    miso_idle = (state_d == ST_IGN) ? IGN_MISO : 1'b0;
  end

  // Out-of-range pointers match no register and read back as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ptr_d == ADDR_W'(i)) rd_val = regs_q[i];
    end
  end

  always_ff @(posedge SCLK) begin
    if (!resetn) begin
      state_q    <= ST_CMD;
      cmd_q      <= '0;
      ptr_q      <= '0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ptr_q      <= ptr_d;
      wr_pulse_q <= commit;
      if (commit) begin
        wr_addr_q <= ptr_q;
        wr_data_q <= sin_d[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge SCLK) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (RESET_IDX != 0) ? DATA_W'(i) : '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ptr_q == ADDR_W'(i)) regs_q[i] <= sin_d[DATA_W-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_img
    assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != ST_CMD) || (cnt != '0);

`ifdef SPI_REG_SLAVE_CMD_ERR_EN
  logic       cmd_err_q;
  logic [7:0] err_cnt_q;
  logic       unk_op;

  assign unk_op = !CS && (state_q == ST_ADDR) && last &&
                  (cmd_q != CMD_READ) && (cmd_q != CMD_WRITE);

  always_ff @(posedge SCLK) begin
    if (!resetn) begin
      cmd_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else if (unk_op) begin
      cmd_err_q <= 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end else if (commit && (ptr_q == ADDR_W'(NUM_REGS - 1))) begin
      cmd_err_q <= 1'b0;
    end
  end

  assign cmd_err = cmd_err_q;
  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomised scoreboard bench for spi_reg_slave (NUM_REGS=20, DATA_W=8, ADDR_W=8, RO_REGS=2).
module tb_spi_reg_slave;
  localparam int NUM_REGS = 20;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 8;
  localparam int RO_REGS  = 2;
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
  localparam logic IGN_BIT = 1'b1;
`else
  localparam logic IGN_BIT = 1'b0;
`endif

  logic                       SCLK   = 1'b0;
  logic                       resetn = 1'b0;
  logic                       CS     = 1'b1;
  logic                       MOSI   = 1'b0;
  logic                       MISO, wr_pulse, busy;
  logic [NUM_REGS*DATA_W-1:0] regs_o;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
  logic                       cmd_err;
  logic [7:0]                 err_cnt;
`endif

  spi_reg_slave #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RO_REGS(RO_REGS), .RESET_IDX(1)
  ) dut (
    .SCLK(SCLK), .resetn(resetn), .CS(CS), .MOSI(MOSI), .MISO(MISO), .regs_o(regs_o),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
    , .cmd_err(cmd_err), .err_cnt(err_cnt)
`endif
  );

  always #5 SCLK = ~SCLK;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] mem [NUM_REGS];
  logic       m_cmd_err;
  int         m_err_cnt;
  logic [7:0] exp_rd_q [$];
  logic [15:0] exp_wr_q [$];
  logic [7:0] tx_q [$];
  logic       rd_smp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [NUM_REGS*DATA_W-1:0] img;
    for (int i = 0; i < NUM_REGS; i++) img[i*DATA_W +: DATA_W] = mem[i];
    n_chk++;
    if (regs_o !== img) begin
      n_err++;
      $display("FAIL %s: regs_o=%h expected %h", name, regs_o, img);
    end
  endtask

  function automatic int nxt(input int p);
    return (p == NUM_REGS - 1) ? 0 : (p + 1) % 256;
  endfunction

  function automatic logic [7:0] model_rd(input int p);
    return (p < NUM_REGS) ? mem[p] : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) mem[i] = 8'(i);
    m_cmd_err = 1'b0;
    m_err_cnt = 0;
  endtask

  task automatic post_checks(input string name);
    check({name, "_busy"}, busy, 0);
    check({name, "_miso"}, MISO, 0);
    check_regs({name, "_regs"});
`ifdef SPI_REG_SLAVE_CMD_ERR_EN
    check({name, "_cmd_err"}, cmd_err, m_cmd_err);
    check({name, "_err_cnt"}, err_cnt, m_err_cnt);
`endif
  endtask

  // Master: predicts the responses, then shifts out cmd, addr and nbits data bits.
  task automatic spi_frame(input string name, input logic [7:0] cmd, input logic [7:0] addr, input int nbits);
    int p;
    bit is_rd, is_wr, is_ign;
    bit bq [$];
    p      = int'(addr);
    is_rd  = (cmd == 8'h0B);
    is_wr  = (cmd == 8'h0A);
    is_ign = !is_rd && !is_wr;
    for (int j = 0; j < nbits / 8; j++) begin
      if (is_rd) exp_rd_q.push_back(model_rd(p));
      else if (is_ign) exp_rd_q.push_back({8{IGN_BIT}});
      else if (p >= RO_REGS && p < NUM_REGS) begin
        mem[p] = tx_q[j];
        exp_wr_q.push_back({8'(p), tx_q[j]});
        if (p == NUM_REGS - 1) m_cmd_err = 1'b0;
      end
      p = nxt(p);
    end
    if (is_ign) begin
      m_cmd_err = 1'b1;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    for (int i = 7; i >= 0; i--) bq.push_back(cmd[i]);
    for (int i = 7; i >= 0; i--) bq.push_back(addr[i]);
    for (int k = 0; k < nbits; k++) bq.push_back(is_wr ? tx_q[k/8][7 - k%8] : 1'($urandom_range(0, 1)));
    for (int i = 0; i < bq.size(); i++) begin
      @(negedge SCLK);
      CS     = 1'b0;
      MOSI   = bq[i];
      rd_smp = (i >= 16) && (is_rd || is_ign);
      if (i == 16) check({name, "_busy_mid"}, busy, 1);
    end
    @(negedge SCLK);
    CS     = 1'b1;
    rd_smp = 1'b0;
    MOSI   = 1'b0;
    @(negedge SCLK);
    post_checks(name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read byte or a write strobe.
  initial begin
    logic [7:0] acc;
    int nb;
    acc = '0;
    nb  = 0;
    forever begin
      @(negedge SCLK);
      #1;
      if (rd_smp) begin
        acc = {acc[6:0], MISO};
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (exp_rd_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL rd_unexpected: got byte %0h with none expected", acc);
          end else check("rd_byte", acc, exp_rd_q.pop_front());
        end
      end
      if (wr_pulse === 1'b1) begin
        if (exp_wr_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL wr_unexpected: addr %0h data %0h with none expected", wr_addr, wr_data);
        end else check("wr_evt", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, nbytes, nbits;
    logic [7:0] cmd, addr;
    model_reset();
    resetn = 1'b0;
    CS     = 1'b1;
    repeat (2) @(negedge SCLK);
    check("rst_miso", MISO, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_reg5", regs_o[5*DATA_W +: DATA_W], 8'h05);
    check_regs("rst_regs");
    resetn = 1'b1;

    spi_frame("burst_wrap", 8'h0B, 8'h12, 32);
    tx_q = '{8'hA5, 8'h5A};
    spi_frame("wr_pair", 8'h0A, 8'h03, 16);
    spi_frame("rd_pair", 8'h0B, 8'h03, 16);
    tx_q = '{8'h3C};
    spi_frame("abort_wr", 8'h0A, 8'h07, 4);
    tx_q = '{8'hFF};
    spi_frame("ro_wr", 8'h0A, 8'h01, 8);
    spi_frame("unknown_op", 8'h55, 8'h00, 16);
    spi_frame("oor_rd", 8'h0B, 8'h40, 8);
    tx_q = '{8'hFF};
    spi_frame("oor_wr", 8'h0A, 8'h40, 8);
    tx_q = '{8'h77};
    spi_frame("wr_last", 8'h0A, 8'(NUM_REGS - 1), 8);
    spi_frame("oor_wrap", 8'h0B, 8'hFF, 16);

    // Reset asserted mid-frame with CS still low.
    for (int i = 0; i < 13; i++) begin
      @(negedge SCLK);
      CS   = 1'b0;
      MOSI = (i < 8) ? 1'(8'h0A >> (7 - i)) : 1'b1;
    end
    @(negedge SCLK);
    resetn = 1'b0;
    @(negedge SCLK);
    model_reset();
    check("rst_mid_busy", busy, 0);
    check_regs("rst_mid_regs");
    resetn = 1'b1;
    CS     = 1'b1;
    spi_frame("after_rst", 8'h0B, 8'h05, 8);

    for (int f = 0; f < 40; f++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cmd = 8'h0B;
      else if (r < 8) cmd = 8'h0A;
      else begin
        cmd = 8'($urandom_range(0, 255));
        if (cmd == 8'h0A || cmd == 8'h0B) cmd = 8'h55;
      end
      addr   = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, NUM_REGS + 3)) : 8'($urandom_range(0, 255));
      nbytes = $urandom_range(1, 4);
      nbits  = nbytes * 8;
      if (cmd == 8'h0A && $urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
      tx_q.delete();
      for (int j = 0; j < nbytes; j++) tx_q.push_back(8'($urandom_range(0, 255)));
      spi_frame("rand", cmd, addr, nbits);
    end

    repeat (3) @(negedge SCLK);
    check("rd_q_drained", exp_rd_q.size(), 0);
    check("wr_q_drained", exp_wr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
